// File: rtl/smpte_pkg.sv
// Shared definitions for the SMPTE test-pattern generator: mode encodings,
// bar colour tables and amplitude level helpers.
package smpte_pkg;

    typedef enum logic [2:0] {
        MODE_FULL_BARS   = 3'd0,
        MODE_SPLIT_FIELD = 3'd1,
        MODE_GRAY_RAMP   = 3'd2,
        MODE_CHECKER     = 3'd3
    } mode_t;

    localparam int unsigned NUM_BARS = 7;

    // Requests 4..7 are unused encodings and fall back to full-field bars.
    function automatic mode_t decode_mode(input logic [2:0] req);
        case (req)
            3'd1:    return MODE_SPLIT_FIELD;
            3'd2:    return MODE_GRAY_RAMP;
            3'd3:    return MODE_CHECKER;
            default: return MODE_FULL_BARS;
        endcase
    endfunction

    // {R,G,B} on/off mask for the main bar strip, bar 0 leftmost.
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] reverse_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b001;
            3'd2:    return 3'b101;
            3'd4:    return 3'b011;
            3'd6:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int unsigned full_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic int unsigned l75_level(input int unsigned bits);
        return full_level(bits) - (full_level(bits) >> 2);
    endfunction

endpackage

// File: rtl/bar_index_counter.sv
// Tracks which colour bar the current visible pixel belongs to; the last bar
// absorbs the remainder when H_DISPLAY is not a multiple of the bar count.
module bar_index_counter
    import smpte_pkg::*;
#(
    parameter int unsigned H_DISPLAY = 256,
    parameter int unsigned H_BITS    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              display_on,
    output logic [2:0]        bar_idx,
    output logic [H_BITS-1:0] bar_cnt
);

    localparam int unsigned       BAR_W    = H_DISPLAY / NUM_BARS;
    localparam logic [H_BITS-1:0] BAR_LAST = H_BITS'(BAR_W - 1);
    localparam logic [2:0]        IDX_LAST = 3'(NUM_BARS - 1);

    always_ff @(posedge clk) begin
        if (!reset || !display_on) begin
            bar_idx <= '0;
            bar_cnt <= '0;
        end else if (bar_cnt == BAR_LAST && bar_idx < IDX_LAST) begin
            bar_idx <= bar_idx + 3'd1;
            bar_cnt <= '0;
        end else begin
            bar_cnt <= bar_cnt + H_BITS'(1);
        end
    end

endmodule

// File: rtl/smpte_pattern_gen.sv
// Multi-mode test-pattern generator: frame-latched mode/amplitude, pattern
// mux and a registered RGB output one pixel behind the beam position.
module smpte_pattern_gen
    import smpte_pkg::*;
#(
    parameter int unsigned H_DISPLAY  = 256,
    parameter int unsigned V_DISPLAY  = 240,
    parameter int unsigned H_BITS     = 9,
    parameter int unsigned V_BITS     = 9,
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned CHECK_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    display_on,
    input  logic [H_BITS-1:0]       hpos,
    input  logic [V_BITS-1:0]       vpos,
    input  logic [2:0]              mode_req,
    input  logic                    amp_full_req,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic                    frame_start
);

    localparam logic [COLOR_BITS-1:0] FULL       = COLOR_BITS'(full_level(COLOR_BITS));
    localparam logic [COLOR_BITS-1:0] L75        = COLOR_BITS'(l75_level(COLOR_BITS));
    localparam logic [V_BITS-1:0]     V1         = V_BITS'((2 * V_DISPLAY) / 3);
    localparam logic [V_BITS-1:0]     V2         = V_BITS'((3 * V_DISPLAY) / 4);
    localparam int unsigned           GRAY_SHIFT = H_BITS - COLOR_BITS;

    logic [2:0]              bar_idx;
    logic [H_BITS-1:0]       bar_cnt;
    logic                    unused_bar_cnt;
    mode_t                   mode_q;
    mode_t                   mode_eff;
    logic                    amp_q;
    logic                    amp_eff;
    logic                    at_origin;
    logic [COLOR_BITS-1:0]   bar_lvl;
    logic [COLOR_BITS-1:0]   on_lvl;
    logic [COLOR_BITS-1:0]   gray;
    logic [H_BITS-1:0]       gray_raw;
    logic [2:0]              on_mask;
    logic [3*COLOR_BITS-1:0] pixel;

    bar_index_counter #(
        .H_DISPLAY (H_DISPLAY),
        .H_BITS    (H_BITS)
    ) u_bar_counter (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .bar_idx    (bar_idx),
        .bar_cnt    (bar_cnt)
    );

    assign unused_bar_cnt = ^bar_cnt;
    assign at_origin      = display_on && (hpos == '0) && (vpos == '0);

    // The origin pixel already uses the freshly requested mode and amplitude.
    always_comb begin
        mode_eff = at_origin ? decode_mode(mode_req) : mode_q;
        amp_eff  = at_origin ? amp_full_req : amp_q;
        bar_lvl  = amp_eff ? FULL : L75;
        gray_raw = hpos >> GRAY_SHIFT;
        gray     = (gray_raw > H_BITS'(FULL)) ? FULL : gray_raw[COLOR_BITS-1:0];
    end

    always_comb begin
        on_mask = '0;
        on_lvl  = bar_lvl;
        pixel   = '0;
        case (mode_eff)
            MODE_SPLIT_FIELD: begin
                if (vpos < V1) begin
                    on_mask = bar_colour(bar_idx);
                end else if (vpos < V2) begin
                    on_mask = reverse_colour(bar_idx);
                end else begin
                    on_lvl  = FULL;
                    on_mask = (bar_idx == 3'd1) ? 3'b111 : 3'b000;
                end
            end
            MODE_GRAY_RAMP: on_mask = '0;
            MODE_CHECKER:   on_mask = {3{hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2]}};
            default:        on_mask = bar_colour(bar_idx);
        endcase
        if (mode_eff == MODE_GRAY_RAMP) begin
            pixel = {gray, gray, gray};
        end else begin
            pixel = {{COLOR_BITS{on_mask[2]}} & on_lvl,
                     {COLOR_BITS{on_mask[1]}} & on_lvl,
                     {COLOR_BITS{on_mask[0]}} & on_lvl};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb         <= '0;
            frame_start <= 1'b0;
            mode_q      <= MODE_FULL_BARS;
            amp_q       <= 1'b0;
        end else begin
            rgb         <= display_on ? pixel : '0;
            frame_start <= at_origin;
            if (at_origin) begin
                mode_q <= mode_eff;
                amp_q  <= amp_eff;
            end
        end
    end

endmodule

// File: tb/tb_smpte_pattern_gen.sv
// Self-checking bench for smpte_pattern_gen: per-pixel reference model on a
// scoreboard queue, a table of spot values, and reset/latch corner sequences.
module tb_smpte_pattern_gen;

    logic        clk;
    logic        reset;
    logic        display_on;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic [2:0]  mode_req;
    logic        amp_full_req;
    logic [11:0] rgb;
    logic        frame_start;

    smpte_pattern_gen #(
        .H_DISPLAY  (256),
        .V_DISPLAY  (240),
        .H_BITS     (9),
        .V_BITS     (9),
        .COLOR_BITS (4),
        .CHECK_LOG2 (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .display_on   (display_on),
        .hpos         (hpos),
        .vpos         (vpos),
        .mode_req     (mode_req),
        .amp_full_req (amp_full_req),
        .rgb          (rgb),
        .frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        fs;
        int          tag;
        int          h;
        int          v;
    } exp_t;

    typedef struct {
        logic [2:0]  m;
        logic        a;
        int          v;
        int          h;
        logic [11:0] c;
    } vec_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference state: latched mode/amp and visible pixels since last blank/reset.
    int   mm = 0;
    logic ma = 1'b0;
    int   vc = 0;

    logic [2:0] bar_tab [7] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001};
    logic [2:0] rev_tab [7] = '{3'b001, 3'b000, 3'b101, 3'b000, 3'b011, 3'b000, 3'b111};

    function automatic logic [11:0] paint(input logic [2:0] msk, input logic [3:0] l);
        return {msk[2] ? l : 4'h0, msk[1] ? l : 4'h0, msk[0] ? l : 4'h0};
    endfunction

    function automatic logic [11:0] model_px(input int m, input logic a, input int h,
                                             input int v, input int cnt);
        logic [3:0] l;
        logic [3:0] g;
        int         b;
        l = a ? 4'hF : 4'hC;
        b = cnt / 36;
        if (b > 6) b = 6;
        case (m)
            1: begin
                if (v < 160)      return paint(bar_tab[b], l);
                else if (v < 180) return paint(rev_tab[b], l);
                else              return (b == 1) ? 12'hFFF : 12'h000;
            end
            2: begin
                g = 4'(h / 32);
                return {g, g, g};
            end
            3: return ((((h / 16) % 2) ^ ((v / 16) % 2)) != 0) ? paint(3'b111, l) : 12'h000;
            default: return paint(bar_tab[b], l);
        endcase
    endfunction

    task automatic drive(input logic rst, input logic d, input int h, input int v,
                         input logic [2:0] m, input logic a,
                         input logic use_c, input logic [11:0] c, input int tag);
        exp_t e;
        exp_t got;
        reset        = rst;
        display_on   = d;
        hpos         = 9'(h);
        vpos         = 9'(v);
        mode_req     = m;
        amp_full_req = a;
        if (!rst) begin
            e.rgb = 12'h000;
            e.fs  = 1'b0;
            mm    = 0;
            ma    = 1'b0;
            vc    = 0;
        end else begin
            if (d && h == 0 && v == 0) begin
                mm = (m > 3'd3) ? 0 : int'(m);
                ma = a;
            end
            e.rgb = d ? model_px(mm, ma, h, v, vc) : 12'h000;
            e.fs  = d && h == 0 && v == 0;
            vc    = d ? vc + 1 : 0;
            if (use_c) e.rgb = c;
        end
        e.tag = tag;
        e.h   = h;
        e.v   = v;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        compared++;
        if (rgb !== got.rgb || frame_start !== got.fs) begin
            mismatched++;
            $display("FAIL pixel tag=%0d h=%0d v=%0d: rgb=%h frame_start=%b, expected rgb=%h frame_start=%b",
                     got.tag, got.h, got.v, rgb, frame_start, got.rgb, got.fs);
        end
    endtask

    // One line: 8 blanking pixels then 256 visible; reset held low for h in [rlo,rhi].
    task automatic run_line(input int v, input logic [2:0] m, input logic a,
                            input int t1, input logic [11:0] c1,
                            input int t2, input logic [11:0] c2,
                            input int rlo, input int rhi, input int tag);
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b0, 256 + i, v, m, a, 1'b0, 12'h000, tag);
        for (int h = 0; h < 256; h++)
            drive(!(h >= rlo && h <= rhi), 1'b1, h, v, m, a,
                  (h == t1) || (h == t2), (h == t1) ? c1 : c2, tag);
    endtask

    vec_t vecs [24];

    initial begin
        vecs[0]  = '{3'd0, 1'b0,   0,   0, 12'hCCC};
        vecs[1]  = '{3'd0, 1'b0,   0,  35, 12'hCCC};
        vecs[2]  = '{3'd0, 1'b0,   0,  36, 12'hCC0};
        vecs[3]  = '{3'd0, 1'b0,   0,  72, 12'h0CC};
        vecs[4]  = '{3'd0, 1'b0,   0, 108, 12'h0C0};
        vecs[5]  = '{3'd0, 1'b0,   0, 144, 12'hC0C};
        vecs[6]  = '{3'd0, 1'b0,   0, 180, 12'hC00};
        vecs[7]  = '{3'd0, 1'b0,   0, 216, 12'h00C};
        vecs[8]  = '{3'd0, 1'b0,   0, 255, 12'h00C};
        vecs[9]  = '{3'd0, 1'b1,   0,   0, 12'hFFF};
        vecs[10] = '{3'd0, 1'b1,   0,  36, 12'hFF0};
        vecs[11] = '{3'd1, 1'b0, 159,  72, 12'h0CC};
        vecs[12] = '{3'd1, 1'b0, 160,   0, 12'h00C};
        vecs[13] = '{3'd1, 1'b0, 160,  36, 12'h000};
        vecs[14] = '{3'd1, 1'b0, 180,  36, 12'hFFF};
        vecs[15] = '{3'd1, 1'b0, 180,   0, 12'h000};
        vecs[16] = '{3'd2, 1'b0,   0,   0, 12'h000};
        vecs[17] = '{3'd2, 1'b0,   0,  32, 12'h111};
        vecs[18] = '{3'd2, 1'b0,   0, 255, 12'h777};
        vecs[19] = '{3'd3, 1'b0,   0,  16, 12'hCCC};
        vecs[20] = '{3'd3, 1'b0,  16,  16, 12'h000};
        vecs[21] = '{3'd3, 1'b0,   0,   0, 12'h000};
        vecs[22] = '{3'd7, 1'b0,   0,  36, 12'hCC0};
        vecs[23] = '{3'd3, 1'b1,   0,  16, 12'hFFF};

        reset        = 1'b0;
        display_on   = 1'b0;
        hpos         = '0;
        vpos         = '0;
        mode_req     = 3'd0;
        amp_full_req = 1'b0;

        // Reset held 3 cycles, including an origin pixel that must not pulse or latch.
        drive(1'b0, 1'b1,   0, 0, 3'd3, 1'b1, 1'b0, 12'h000, 1);
        drive(1'b0, 1'b0, 300, 0, 3'd0, 1'b0, 1'b0, 12'h000, 1);
        drive(1'b0, 1'b0, 301, 0, 3'd0, 1'b0, 1'b0, 12'h000, 1);

        for (int i = 0; i < 24; i++) begin
            run_line(0, vecs[i].m, vecs[i].a, (vecs[i].v == 0) ? vecs[i].h : -1, vecs[i].c,
                     -1, 12'h000, -1, -1, 100 + i);
            if (vecs[i].v != 0)
                run_line(vecs[i].v, vecs[i].m, vecs[i].a, vecs[i].h, vecs[i].c,
                         -1, 12'h000, -1, -1, 100 + i);
        end

        // Mid-frame request changes stay invisible until the next origin pixel.
        run_line(0,  3'd0, 1'b1, 0, 12'hFFF, 36, 12'hFF0, -1, -1, 200);
        run_line(10, 3'd3, 1'b0, 0, 12'hFFF, 36, 12'hFF0, -1, -1, 201);
        run_line(0,  3'd0, 1'b0, 0, 12'hCCC, 36, 12'hCC0, -1, -1, 202);

        // Reset mid-line with checker active: bars restart from the release point.
        run_line(0,  3'd3, 1'b0, 16,  12'hCCC, -1,  12'h000, -1,  -1,  300);
        run_line(50, 3'd3, 1'b0, 103, 12'hCCC, 139, 12'hCC0, 100, 102, 301);
        run_line(51, 3'd3, 1'b0, 36,  12'hCC0, 72,  12'h0CC, -1,  -1,  302);
        run_line(0,  3'd7, 1'b1, 0,   12'hFFF, 216, 12'h00F, -1,  -1,  303);

        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 256 + i, 1, 3'd0, 1'b0, 1'b0, 12'h000, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
